// File: rtl/nibble_lane_tx.sv
// Packet framer: buffers one packet from a valid/ready byte stream, then serialises it
// onto a 4-bit lane as SYNC, LEN, payload and checksum nibbles, low nibble first.
module nibble_lane_tx #(
   parameter int MAX_LEN  = 64,
   parameter int IDLE_GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [3:0] nib_out,
   output logic       frame_out,
   output logic       busy,
   output logic       tx_done
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

   typedef enum logic [2:0] {IDLE, FILL, SYNC, LEN, DATA, CSUM, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    count_q, count_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    idx_q, idx_d;
   logic          half_q, half_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [3:0]    nib_q, nib_d;
   logic          frame_q, frame_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [7:0]    payload_q [2**AW];
   logic          wr_en;
   logic          accept;
   logic [7:0]    cur_byte;
   logic [7:0]    nxt_byte;
   logic [7:0]    csum_total;
   logic [AW-1:0] nxt_addr;

   assign s_ready    = !rst && (state_q == IDLE || state_q == FILL);
   assign accept     = s_valid && s_ready;
   assign nxt_addr   = AW'(idx_q + 8'd1);
   assign cur_byte   = payload_q[idx_q[AW-1:0]];
   assign nxt_byte   = payload_q[nxt_addr];
   assign csum_total = csum_q + count_q;

   // Outputs are computed for the state being entered, so registering them adds no lag.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      csum_d  = csum_q;
      idx_d   = idx_q;
      half_d  = half_q;
      gap_d   = gap_q;
      nib_d   = 4'h0;
      frame_d = 1'b0;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE, FILL: begin
            if (accept) begin
               wr_en   = 1'b1;
               count_d = count_q + 8'd1;
               csum_d  = csum_q + s_data;
               if (s_last || count_d == 8'(MAX_LEN)) begin
                  state_d = SYNC;
                  half_d  = 1'b0;
                  idx_d   = 8'd0;
                  nib_d   = 4'hA;
                  frame_d = 1'b1;
               end else begin
                  state_d = FILL;
               end
            end
         end
         SYNC: begin
            frame_d = 1'b1;
            if (!half_q) begin
               half_d = 1'b1;
               nib_d  = 4'h5;
            end else begin
               state_d = LEN;
               half_d  = 1'b0;
               nib_d   = count_q[3:0];
            end
         end
         LEN: begin
            frame_d = 1'b1;
            if (!half_q) begin
               half_d = 1'b1;
               nib_d  = count_q[7:4];
            end else begin
               state_d = DATA;
               half_d  = 1'b0;
               nib_d   = cur_byte[3:0];
            end
         end
         DATA: begin
            frame_d = 1'b1;
            if (!half_q) begin
               half_d = 1'b1;
               nib_d  = cur_byte[7:4];
            end else if (idx_q == count_q - 8'd1) begin
               state_d = CSUM;
               half_d  = 1'b0;
               nib_d   = csum_total[3:0];
            end else begin
               half_d = 1'b0;
               idx_d  = idx_q + 8'd1;
               nib_d  = nxt_byte[3:0];
            end
         end
         CSUM: begin
            if (!half_q) begin
               frame_d = 1'b1;
               half_d  = 1'b1;
               nib_d   = csum_total[7:4];
            end else begin
               state_d = GAP;
               half_d  = 1'b0;
               gap_d   = '0;
               done_d  = 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GW'(IDLE_GAP - 1)) begin
               state_d = IDLE;
               count_d = 8'd0;
               csum_d  = 8'd0;
               idx_d   = 8'd0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 8'd0;
         csum_q  <= 8'd0;
         idx_q   <= 8'd0;
         half_q  <= 1'b0;
         gap_q   <= '0;
         nib_q   <= 4'h0;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         csum_q  <= csum_d;
         idx_q   <= idx_d;
         half_q  <= half_d;
         gap_q   <= gap_d;
         nib_q   <= nib_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Payload storage needs no reset; stale bytes are never read past count.
   always_ff @(posedge clk) begin
      if (wr_en) payload_q[count_q[AW-1:0]] <= s_data;
   end

   assign nib_out   = nib_q;
   assign frame_out = frame_q;
   assign busy      = busy_q;
   assign tx_done   = done_q;

endmodule
